core_mem_stage: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Registers execute results (ALU result, forwarded rs2 store data, rd, control) and runs a load/store unit FSM against a req/gnt/rvalid data-memory port.
- Produces a registered write-back bundle for the WB stage, which feeds the WB forwarding path, and stalls upstream while a memory access is outstanding.

---
 rtl/core_mem_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_core_mem_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_stage.sv
// ============================================================================
// Module      : core_mem_stage
// Description : Memory stage: registers execute results, runs the load/store
//               unit against a req/gnt/rvalid data port, emits a WB bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module core_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    input  logic            i_reg_write,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_stall,
    output logic            o_dmem_req,
    input  logic            i_dmem_gnt,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic            o_dmem_we,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_valid,
    output logic            o_wb_reg_write,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_exc
);

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_is_store;
    logic [XLEN-1:0] r_store_data;

    logic            r_wb_valid;
    logic            r_wb_reg_write;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_exc;

    logic            w_idle;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    logic            w_f3_legal;
    logic            w_misaligned;
    logic            w_mem_ok;
    logic            w_mem_bad;
    logic            w_req;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_rshift_b;
    logic [XLEN-1:0] w_rshift_h;
    logic [7:0]      w_rbyte;
    logic [15:0]     w_rhalf;
    logic [XLEN-1:0] w_load_data;

    // ------------------------------------------------------------------
    // Issue decode (only meaningful while idle)
    // ------------------------------------------------------------------
    assign w_idle     = (r_state == ST_IDLE);
    assign w_is_load  = (i_opcode == c_OP_LOAD);
    assign w_is_store = (i_opcode == c_OP_STORE);
    assign w_is_mem   = w_is_load | w_is_store;

    always_comb begin
        w_f3_legal = 1'b0;
        if (w_is_load) begin
            w_f3_legal = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                         (i_funct3 == 3'd4) || (i_funct3 == 3'd5);
        end else if (w_is_store) begin
            w_f3_legal = (i_funct3 == 3'd0) || (i_funct3 == 3'd1) || (i_funct3 == 3'd2);
        end
    end

    assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_alu_result[0]) ||
                          ((i_funct3[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00));
    assign w_mem_ok     = w_is_mem & w_f3_legal & ~w_misaligned;
    assign w_mem_bad    = w_is_mem & ~(w_f3_legal & ~w_misaligned);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_valid && w_mem_ok) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_dmem_gnt) begin
                    w_state_nxt = r_is_store ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_dmem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Access latch: captured once at issue, stable for the whole access
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr       <= '0;
            r_funct3     <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_is_store   <= 1'b0;
            r_store_data <= '0;
        end else if (w_idle && i_valid && w_mem_ok) begin
            r_addr       <= i_alu_result;
            r_funct3     <= i_funct3;
            r_rd         <= i_rd;
            r_reg_write  <= i_reg_write;
            r_is_store   <= w_is_store;
            r_store_data <= i_store_data;
        end
    end

    // ------------------------------------------------------------------
    // Request lanes
    // ------------------------------------------------------------------
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_store_data;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {(XLEN/8){r_store_data[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << r_addr[1:0];
                w_wdata = {(XLEN/16){r_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_store_data;
            end
        endcase
    end

    // Port is quiet outside REQ so reset and idle both present all-zero
    assign w_req        = (r_state == ST_REQ);
    assign o_dmem_req   = w_req;
    assign o_dmem_addr  = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign o_dmem_we    = w_req & r_is_store;
    assign o_dmem_be    = w_req ? w_be : 4'b0000;
    assign o_dmem_wdata = w_req ? w_wdata : '0;

    // ------------------------------------------------------------------
    // Load data formatting
    // ------------------------------------------------------------------
    assign w_rshift_b = i_dmem_rdata >> {r_addr[1:0], 3'b000};
    assign w_rshift_h = i_dmem_rdata >> {r_addr[1], 4'b0000};
    assign w_rbyte    = w_rshift_b[7:0];
    assign w_rhalf    = w_rshift_h[15:0];

    always_comb begin
        w_load_data = i_dmem_rdata;
        case (r_funct3)
            3'd0:    w_load_data = {{(XLEN-8){w_rbyte[7]}}, w_rbyte};
            3'd1:    w_load_data = {{(XLEN-16){w_rhalf[15]}}, w_rhalf};
            3'd4:    w_load_data = {{(XLEN-8){1'b0}}, w_rbyte};
            3'd5:    w_load_data = {{(XLEN-16){1'b0}}, w_rhalf};
            default: w_load_data = i_dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Write-back bundle: valid/exc pulse, data/rd hold between pulses
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_exc          <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_exc      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_valid && !w_is_mem) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_data      <= i_alu_result;
                        r_wb_rd        <= i_rd;
                        r_wb_reg_write <= i_reg_write & (i_rd != 5'd0);
                    end else if (i_valid && w_mem_bad) begin
                        r_wb_valid     <= 1'b1;
                        r_exc          <= 1'b1;
                        r_wb_data      <= i_alu_result;
                        r_wb_rd        <= i_rd;
                        r_wb_reg_write <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (i_dmem_gnt && r_is_store) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_rd        <= r_rd;
                        r_wb_reg_write <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_dmem_rvalid) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_data      <= w_load_data;
                        r_wb_rd        <= r_rd;
                        r_wb_reg_write <= r_reg_write & (r_rd != 5'd0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_stall        = (r_state != ST_IDLE);
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_reg_write = r_wb_reg_write;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_exc          = r_exc;

endmodule

`default_nettype wire

// File: tb/tb_core_mem_stage.sv
// ============================================================================
// Module      : tb_core_mem_stage
// Description : Vector table plus scoreboard bench for core_mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_core_mem_stage;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_ALU   = 7'b0110011;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic        o_stall;
    logic        o_dmem_req;
    logic        i_dmem_gnt;
    logic [31:0] o_dmem_addr;
    logic        o_dmem_we;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic        o_wb_reg_write;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_exc;

    core_mem_stage #(.XLEN(32)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_valid        (i_valid),
        .i_opcode       (i_opcode),
        .i_funct3       (i_funct3),
        .i_rd           (i_rd),
        .i_reg_write    (i_reg_write),
        .i_alu_result   (i_alu_result),
        .i_store_data   (i_store_data),
        .o_stall        (o_stall),
        .o_dmem_req     (o_dmem_req),
        .i_dmem_gnt     (i_dmem_gnt),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_be      (o_dmem_be),
        .o_dmem_wdata   (o_dmem_wdata),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_wb_valid     (o_wb_valid),
        .o_wb_reg_write (o_wb_reg_write),
        .o_wb_rd        (o_wb_rd),
        .o_wb_data      (o_wb_data),
        .o_exc          (o_exc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          gd;
        int          rv;
        logic        mem;
        logic [31:0] exp_data;
        logic        chk_data;
        logic        exp_rw;
        logic        exp_exc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        chk_wdata;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  rd;
        logic        rw;
        logic        exc;
    } exp_t;

    vec_t vq[$];
    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every write-back pulse must match the oldest issue
    always @(negedge i_clk) begin
        if (o_wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wb: got wb_valid=1 expected no write-back");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_reg_write"}, 32'(o_wb_reg_write), 32'(mon_e.rw));
                chk({mon_e.name, "_exc"}, 32'(o_exc), 32'(mon_e.exc));
                if (mon_e.chk_data) begin
                    chk({mon_e.name, "_data"}, o_wb_data, mon_e.data);
                    chk({mon_e.name, "_rd"}, 32'(o_wb_rd), 32'(mon_e.rd));
                end
            end
        end
    end

    task automatic add_vec(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] rd, input logic rw, input logic [31:0] alu,
                           input logic [31:0] sdata, input logic [31:0] rdata, input int gd,
                           input int rv, input logic mem, input logic [31:0] exp_data,
                           input logic chk_data, input logic exp_rw, input logic exp_exc,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic chk_wdata);
        vec_t v;
        v.name = name; v.op = op; v.f3 = f3; v.rd = rd; v.rw = rw; v.alu = alu;
        v.sdata = sdata; v.rdata = rdata; v.gd = gd; v.rv = rv; v.mem = mem;
        v.exp_data = exp_data; v.chk_data = chk_data; v.exp_rw = exp_rw;
        v.exp_exc = exp_exc; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.chk_wdata = chk_wdata;
        vq.push_back(v);
    endtask

    // Drives ADD junk while stalled; all of it must be ignored
    task automatic drive_junk();
        i_valid      = 1'b1;
        i_opcode     = c_OP_ALU;
        i_funct3     = 3'd0;
        i_rd         = 5'd31;
        i_reg_write  = 1'b1;
        i_alu_result = 32'h0BAD_0BAD;
        i_store_data = 32'hFFFF_FFFF;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        i_valid      = 1'b1;
        i_opcode     = v.op;
        i_funct3     = v.f3;
        i_rd         = v.rd;
        i_reg_write  = v.rw;
        i_alu_result = v.alu;
        i_store_data = v.sdata;
        e.name = v.name; e.data = v.exp_data; e.chk_data = v.chk_data;
        e.rd = v.rd; e.rw = v.exp_rw; e.exc = v.exp_exc;
        sb.push_back(e);
        @(negedge i_clk);
        if (v.mem) begin
            drive_junk();
            for (int k = 0; k <= v.gd; k++) begin
                chk({v.name, "_req"}, 32'(o_dmem_req), 32'd1);
                chk({v.name, "_stall"}, 32'(o_stall), 32'd1);
                chk({v.name, "_addr"}, o_dmem_addr, {v.alu[31:2], 2'b00});
                chk({v.name, "_be"}, 32'(o_dmem_be), 32'(v.exp_be));
                chk({v.name, "_we"}, 32'(o_dmem_we), 32'(v.op == c_OP_STORE));
                if (v.chk_wdata) chk({v.name, "_wdata"}, o_dmem_wdata, v.exp_wdata);
                i_dmem_gnt    = (k == v.gd);
                i_dmem_rvalid = (k != v.gd);
                i_dmem_rdata  = 32'h5A5A_5A5A;
                @(negedge i_clk);
            end
            i_dmem_gnt    = 1'b0;
            i_dmem_rvalid = 1'b0;
            if (v.op == c_OP_LOAD) begin
                for (int j = 1; j < v.rv; j++) begin
                    chk({v.name, "_wait_req"}, 32'(o_dmem_req), 32'd0);
                    chk({v.name, "_wait_stall"}, 32'(o_stall), 32'd1);
                    @(negedge i_clk);
                end
                i_dmem_rvalid = 1'b1;
                i_dmem_rdata  = v.rdata;
                @(negedge i_clk);
                i_dmem_rvalid = 1'b0;
                i_dmem_rdata  = 32'h0;
            end
        end else begin
            chk({v.name, "_noreq"}, 32'(o_dmem_req), 32'd0);
        end
        i_valid = 1'b0;
        chk({v.name, "_wb_valid"}, 32'(o_wb_valid), 32'd1);
        chk({v.name, "_wb_stall"}, 32'(o_stall), 32'd0);
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_opcode = '0; i_funct3 = '0; i_rd = '0;
        i_reg_write = 1'b0; i_alu_result = '0; i_store_data = '0;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;

        //      name        op          f3   rd  rw alu            sdata          rdata          gd rv mem exp_data       chk rw exc be       wdata          chkw
        add_vec("add_rd5",  c_OP_ALU,   3'd0, 5, 1, 32'h0000_1234, 32'h0,         32'h0,         0, 0, 0, 32'h0000_1234, 1, 1, 0, 4'b0000, 32'h0,         0);
        add_vec("add_rd0",  c_OP_ALU,   3'd0, 0, 1, 32'h0000_1234, 32'h0,         32'h0,         0, 0, 0, 32'h0000_1234, 1, 0, 0, 4'b0000, 32'h0,         0);
        add_vec("sb_103",   c_OP_STORE, 3'd0, 9, 0, 32'h0000_0103, 32'h0000_00A5, 32'h0,         2, 0, 1, 32'h0,         0, 0, 0, 4'b1000, 32'hA5A5_A5A5, 1);
        add_vec("lb_102",   c_OP_LOAD,  3'd0, 7, 1, 32'h0000_0102, 32'h0,         32'h0080_0000, 0, 3, 1, 32'hFFFF_FF80, 1, 1, 0, 4'b0100, 32'h0,         0);
        add_vec("lbu_102",  c_OP_LOAD,  3'd4, 8, 1, 32'h0000_0102, 32'h0,         32'h0080_0000, 0, 3, 1, 32'h0000_0080, 1, 1, 0, 4'b0100, 32'h0,         0);
        add_vec("lh_mis",   c_OP_LOAD,  3'd1, 4, 1, 32'h0000_0101, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0, 1, 4'b0000, 32'h0,         0);
        add_vec("ld_f3_3",  c_OP_LOAD,  3'd3, 4, 1, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0, 1, 4'b0000, 32'h0,         0);
        add_vec("lw_200",   c_OP_LOAD,  3'd2, 6, 1, 32'h0000_0200, 32'h0,         32'hDEAD_BEEF, 1, 1, 1, 32'hDEAD_BEEF, 1, 1, 0, 4'b1111, 32'h0,         0);
        add_vec("add_b2b",  c_OP_ALU,   3'd0, 3, 1, 32'h0000_0055, 32'h0,         32'h0,         0, 0, 0, 32'h0000_0055, 1, 1, 0, 4'b0000, 32'h0,         0);
        add_vec("sh_102",   c_OP_STORE, 3'd1, 2, 0, 32'h0000_0102, 32'h1234_BEEF, 32'h0,         0, 0, 1, 32'h0,         0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 1);
        add_vec("sw_204",   c_OP_STORE, 3'd2, 2, 0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,         1, 0, 1, 32'h0,         0, 0, 0, 4'b1111, 32'hCAFE_F00D, 1);
        add_vec("lh_102",   c_OP_LOAD,  3'd1, 10,1, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 2, 1, 32'hFFFF_8001, 1, 1, 0, 4'b1100, 32'h0,         0);
        add_vec("lhu_rd0",  c_OP_LOAD,  3'd5, 0, 1, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 1, 1, 32'h0000_8001, 1, 0, 0, 4'b1100, 32'h0,         0);
        add_vec("st_f3_4",  c_OP_STORE, 3'd4, 1, 0, 32'h0000_0100, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0, 1, 4'b0000, 32'h0,         0);
        add_vec("sw_mis",   c_OP_STORE, 3'd2, 1, 0, 32'h0000_0202, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0, 1, 4'b0000, 32'h0,         0);
        add_vec("lb_b2b",   c_OP_LOAD,  3'd0, 11,1, 32'h0000_0301, 32'h0,         32'h1122_3344, 2, 1, 1, 32'h0000_0033, 1, 1, 0, 4'b0010, 32'h0,         0);

        repeat (2) @(negedge i_clk);
        chk("rst_stall", 32'(o_stall), 32'd0);
        chk("rst_req", 32'(o_dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("rst_exc", 32'(o_exc), 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_wb_rd", 32'(o_wb_rd), 32'd0);
        chk("rst_be", 32'(o_dmem_be), 32'd0);
        chk("rst_we", 32'(o_dmem_we), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        foreach (vq[i]) run_vec(vq[i]);

        // Stale rvalid while idle must not produce a write-back
        @(negedge i_clk);
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h7777_7777;
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        chk("stale_rv_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("stale_rv_stall", 32'(o_stall), 32'd0);

        // Asynchronous reset in the middle of a load wait
        i_valid = 1'b1; i_opcode = c_OP_LOAD; i_funct3 = 3'd2; i_rd = 5'd12;
        i_reg_write = 1'b1; i_alu_result = 32'h0000_0300;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_dmem_gnt = 1'b1;
        @(negedge i_clk);
        i_dmem_gnt = 1'b0;
        chk("rstw_pre_stall", 32'(o_stall), 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("rstw_req", 32'(o_dmem_req), 32'd0);
        chk("rstw_stall", 32'(o_stall), 32'd0);
        chk("rstw_wb_valid", 32'(o_wb_valid), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h1234_5678;
        @(negedge i_clk);
        i_dmem_rvalid = 1'b0;
        chk("rstw_late_rv_wb", 32'(o_wb_valid), 32'd0);
        @(negedge i_clk);
        chk("rstw_late_rv_wb2", 32'(o_wb_valid), 32'd0);
        chk("rstw_late_stall", 32'(o_stall), 32'd0);

        repeat (2) @(negedge i_clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
